reglk_bank_ctrl: RTL and testbench

- Next-generation register-lock bank: holds the 8-bit lock field of each of NB_PERIPHERALS peripherals in a memory-mapped bank.
- Sits behind axi_lite_interface on the simple en/we/address/data interface.
- Adds shadow/active double-buffering with atomic commit, a sticky lock-until-reset state, and a saturating access-violation counter with a pulse output.
- reglk_ctrl_o drives the per-peripheral lock inputs across the tile.

---
 rtl/reglk_bank_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_reglk_bank_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reglk_bank_ctrl.sv
// Register-lock bank: shadow lock words committed atomically into active words,
// plus a sticky lock-until-reset state and a saturating access-violation counter.
module reglk_bank_ctrl #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int NB_PERIPHERALS = 24,
    parameter int LK_BITS        = 8,
    parameter int VIOL_W         = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               lock_wr_i,
    input  logic                               lock_rd_i,
    input  logic                               en_i,
    input  logic                               we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]          addr_i,
    input  logic [63:0]                        wdata_i,
    output logic [63:0]                        rdata_o,
    output logic                               err_o,
    output logic                               viol_o,
    output logic                               locked_o,
    output logic [LK_BITS*NB_PERIPHERALS-1:0]  reglk_ctrl_o
);

    localparam int NB_BITS  = LK_BITS * NB_PERIPHERALS;
    localparam int NB_WORDS = (NB_BITS + 31) / 32;

    localparam logic [4:0] IDX_ACT  = 5'd28;
    localparam logic [4:0] IDX_SEL  = 5'd29;
    localparam logic [4:0] IDX_VIOL = 5'd30;
    localparam logic [4:0] IDX_CTRL = 5'd31;
    localparam logic [VIOL_W-1:0] VIOL_MAX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_COMMIT,
        ST_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic               lock_after_q, lock_after_d;
    logic [31:0]        shadow_q [NB_WORDS];
    logic [31:0]        shadow_d [NB_WORDS];
    logic [31:0]        active_q [NB_WORDS];
    logic [31:0]        active_d [NB_WORDS];
    logic [4:0]         sel_q, sel_d;
    logic [VIOL_W-1:0]  viol_cnt_q, viol_cnt_d;
    logic               viol_q, viol_d;

    logic [4:0]         idx;
    logic               is_shadow;
    logic               is_mapped;
    logic               clear_only;
    logic               blocked;
    logic               wr_access;
    logic               reject;
    logic               accept;
    logic [31:0]        rdata32;
    logic [NB_WORDS*32-1:0] active_flat;
    logic               unused_bits;

    // Access interface: en_i is a one-cycle strobe with no back-pressure; a write
    // takes effect on the edge that samples it, a read is answered in the same cycle.
    assign idx        = addr_i[7:3];
    assign is_shadow  = (int'(idx) < NB_WORDS) && (idx < IDX_ACT);
    assign is_mapped  = is_shadow || (idx >= IDX_ACT);
    assign clear_only = (wdata_i[31:0] == 32'h8000_0000);
    assign wr_access  = en_i && we_i;

    always_comb begin
        blocked = 1'b0;
        case (state_q)
            ST_LOCKED: blocked = is_shadow || (idx == IDX_SEL) || ((idx == IDX_CTRL) && !clear_only);
            ST_COMMIT: blocked = (idx == IDX_CTRL);
            default:   blocked = 1'b0;
        endcase
    end

    // Writes to unmapped indices are silently dropped and never counted.
    assign reject = wr_access && is_mapped && (lock_wr_i || blocked);
    assign accept = wr_access && !reject;

    always_comb begin
        state_d      = state_q;
        lock_after_d = lock_after_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        sel_d        = sel_q;
        viol_cnt_d   = viol_cnt_q;
        viol_d       = reject;

        // The commit copies shadow as it stood entering the cycle; a shadow write
        // accepted in the same cycle lands after the copy.
        if (state_q == ST_COMMIT) begin
            active_d = shadow_q;
            state_d  = lock_after_q ? ST_LOCKED : ST_UNLOCKED;
        end

        if (accept) begin
            for (int i = 0; i < NB_WORDS; i++) begin
                if (is_shadow && (idx == 5'(i))) begin
                    shadow_d[i] = wdata_i[31:0];
                end
            end
            if (idx == IDX_SEL) begin
                sel_d = wdata_i[4:0];
            end
            if (idx == IDX_CTRL) begin
                if (wdata_i[31]) begin
                    viol_cnt_d = '0;
                end
                if (state_q == ST_UNLOCKED) begin
                    if (wdata_i[0]) begin
                        state_d      = ST_COMMIT;
                        lock_after_d = wdata_i[1];
                    end else if (wdata_i[1]) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
        end

        if (reject && (viol_cnt_q != VIOL_MAX)) begin
            viol_cnt_d = viol_cnt_q + VIOL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_UNLOCKED;
            lock_after_q <= 1'b0;
            sel_q        <= '0;
            viol_cnt_q   <= '0;
            viol_q       <= 1'b0;
            for (int i = 0; i < NB_WORDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lock_after_q <= lock_after_d;
            sel_q        <= sel_d;
            viol_cnt_q   <= viol_cnt_d;
            viol_q       <= viol_d;
            for (int i = 0; i < NB_WORDS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    always_comb begin
        rdata32 = '0;
        case (idx)
            IDX_ACT: begin
                for (int i = 0; i < NB_WORDS; i++) begin
                    if (!lock_rd_i && (sel_q == 5'(i))) begin
                        rdata32 = active_q[i];
                    end
                end
            end
            IDX_SEL:  rdata32 = {27'b0, sel_q};
            IDX_VIOL: rdata32[VIOL_W-1:0] = viol_cnt_q;
            IDX_CTRL: rdata32 = {30'b0, (state_q == ST_LOCKED), (state_q == ST_COMMIT)};
            default: begin
                for (int i = 0; i < NB_WORDS; i++) begin
                    if (is_shadow && !lock_rd_i && (idx == 5'(i))) begin
                        rdata32 = shadow_q[i];
                    end
                end
            end
        endcase
    end

    always_comb begin
        active_flat = '0;
        for (int i = 0; i < NB_WORDS; i++) begin
            active_flat[i*32 +: 32] = active_q[i];
        end
    end

    assign rdata_o      = {32'b0, rdata32};
    assign err_o        = reject;
    assign viol_o       = viol_q;
    assign locked_o     = (state_q == ST_LOCKED);
    assign reglk_ctrl_o = active_flat[NB_BITS-1:0];

    assign unused_bits = ^{wdata_i[63:32], addr_i[AXI_ADDR_WIDTH-1:8], addr_i[2:0], active_flat};

endmodule

// File: tb/tb_reglk_bank_ctrl.sv
// Self-checking bench for reglk_bank_ctrl: a vector table for single-cycle register
// behaviour plus hand-written sequences for commit, lock, reset and saturation.
module tb_reglk_bank_ctrl;

    localparam int NB_WORDS = 6;
    localparam int NB_BITS  = 192;

    logic                clk;
    logic                rst;
    logic                lock_wr;
    logic                lock_rd;
    logic                en;
    logic                we;
    logic [63:0]         addr;
    logic [63:0]         wdata;
    logic [63:0]         rdata;
    logic                err;
    logic                viol;
    logic                locked;
    logic [NB_BITS-1:0]  reglk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] model [NB_WORDS];

    reglk_bank_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lock_wr_i    (lock_wr),
        .lock_rd_i    (lock_rd),
        .en_i         (en),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .err_o        (err),
        .viol_o       (viol),
        .locked_o     (locked),
        .reglk_ctrl_o (reglk)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: called at a falling edge, holds the access for one cycle, samples
    // combinational outputs mid-cycle and returns at the next falling edge.
    task automatic access(input logic w, input logic [4:0] idx, input logic [31:0] wd,
                          output logic [63:0] rd, output logic e);
        en    = 1'b1;
        we    = w;
        addr  = {$urandom, 19'($urandom), idx, 3'($urandom)};
        wdata = {$urandom, wd};
        #2;
        rd = rdata;
        e  = err;
        @(negedge clk);
        en = 1'b0;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] idx, input logic [31:0] exp);
        logic [63:0] rd;
        logic        e;
        exp_q.push_back({32'b0, exp});
        access(1'b0, idx, 32'h0, rd, e);
        check(name, rd, exp_q.pop_front());
    endtask

    task automatic wr_chk(input string name, input logic [4:0] idx, input logic [31:0] d,
                          input logic exp_err);
        logic [63:0] rd;
        logic        e;
        access(1'b1, idx, d, rd, e);
        check(name, 64'(e), 64'(exp_err));
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    function automatic void add_vec(input logic w, input logic [4:0] idx, input logic [31:0] d,
                                    input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.idx = idx; v.wdata = d; v.exp_rd = er; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [63:0]        rd;
        logic               e;
        logic [NB_BITS-1:0] flat;

        rst = 1'b1; lock_wr = 1'b0; lock_rd = 1'b0;
        en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle();

        check("rst_reglk", 64'(reglk[63:0]) | 64'(reglk[191:64] != 0), 64'h0);
        check("rst_locked", 64'(locked), 64'h0);
        check("rst_viol", 64'(viol), 64'h0);

        for (int i = 0; i <= 5; i++) add_vec(1'b0, 5'(i), 32'h0, 32'h0, 1'b0);
        add_vec(1'b0, 5'd31, 32'h0, 32'h0, 1'b0);
        add_vec(1'b0, 5'd30, 32'h0, 32'h0, 1'b0);
        add_vec(1'b1, 5'd2,  32'hA5A5_0F0F, 32'h0, 1'b0);
        add_vec(1'b0, 5'd2,  32'h0, 32'hA5A5_0F0F, 1'b0);
        add_vec(1'b1, 5'd5,  32'h1122_3344, 32'h0, 1'b0);
        add_vec(1'b0, 5'd5,  32'h0, 32'h1122_3344, 1'b0);
        add_vec(1'b1, 5'd10, 32'hFFFF_FFFF, 32'h0, 1'b0);
        add_vec(1'b0, 5'd10, 32'h0, 32'h0, 1'b0);
        add_vec(1'b1, 5'd30, 32'h0000_00FF, 32'h0, 1'b0);
        add_vec(1'b0, 5'd30, 32'h0, 32'h0, 1'b0);
        add_vec(1'b1, 5'd29, 32'h0000_001F, 32'h0, 1'b0);
        add_vec(1'b0, 5'd29, 32'h0, 32'h0000_001F, 1'b0);
        add_vec(1'b0, 5'd28, 32'h0, 32'h0, 1'b0);
        add_vec(1'b1, 5'd29, 32'hFFFF_FFE2, 32'h0, 1'b0);
        add_vec(1'b0, 5'd29, 32'h0, 32'h0000_0002, 1'b0);
        add_vec(1'b0, 5'd28, 32'h0, 32'h0, 1'b0);

        foreach (vecs[k]) begin
            if (!vecs[k].we) exp_q.push_back({32'b0, vecs[k].exp_rd});
            access(vecs[k].we, vecs[k].idx, vecs[k].wdata, rd, e);
            check($sformatf("vec%0d_err", k), 64'(e), 64'(vecs[k].exp_err));
            if (!vecs[k].we) check($sformatf("vec%0d_rd", k), rd, exp_q.pop_front());
        end
        check("vec_no_viol", 64'(viol), 64'h0);

        // First commit: active visible two edges after the CTRL write edge
        check("pre_commit_w2", 64'(reglk[95:64]), 64'h0);
        wr_chk("commit1_err", 5'd31, 32'h1, 1'b0);
        check("commit1_edge1", 64'(reglk[95:64]), 64'h0);
        rd_chk("commit1_pending", 5'd31, 32'h1);
        check("commit1_w2", 64'(reglk[95:64]), 64'hA5A5_0F0F);
        check("commit1_w5", 64'(reglk[191:160]), 64'h1122_3344);
        rd_chk("commit1_act_rd", 5'd28, 32'hA5A5_0F0F);
        rd_chk("commit1_done", 5'd31, 32'h0);

        // CTRL write during COMMIT is rejected
        wr_chk("commit2", 5'd31, 32'h1, 1'b0);
        wr_chk("ctrl_in_commit_err", 5'd31, 32'h1, 1'b1);
        check("ctrl_in_commit_viol", 64'(viol), 64'h1);
        rd_chk("ctrl_in_commit_cnt", 5'd30, 32'h1);

        // Shadow write during COMMIT lands after the copy
        wr_chk("commit3", 5'd31, 32'h1, 1'b0);
        wr_chk("shadow_in_commit_err", 5'd0, 32'h0000_1234, 1'b0);
        check("shadow_in_commit_act", 64'(reglk[31:0]), 64'h0);
        rd_chk("shadow_in_commit_sh", 5'd0, 32'h0000_1234);
        wr_chk("commit4_clear", 5'd31, 32'h8000_0001, 1'b0);
        idle();
        check("commit4_act", 64'(reglk[31:0]), 64'h0000_1234);
        rd_chk("commit4_viol_cleared", 5'd30, 32'h0);

        // Commit then lock
        wr_chk("lock_cmd", 5'd31, 32'h3, 1'b0);
        rd_chk("lock_pending", 5'd31, 32'h1);
        check("lock_locked", 64'(locked), 64'h1);
        rd_chk("lock_ctrl_rd", 5'd31, 32'h2);
        wr_chk("lock_sh_err", 5'd0, 32'hFFFF_FFFF, 1'b1);
        check("lock_viol_pulse", 64'(viol), 64'h1);
        idle();
        check("lock_viol_drop", 64'(viol), 64'h0);
        rd_chk("lock_cnt1", 5'd30, 32'h1);
        rd_chk("lock_sh_unchanged", 5'd0, 32'h0000_1234);
        wr_chk("lock_sel_err", 5'd29, 32'h0, 1'b1);
        wr_chk("lock_ctrl_mix_err", 5'd31, 32'h8000_0001, 1'b1);
        rd_chk("lock_cnt3", 5'd30, 32'h3);
        rd_chk("lock_sel_kept", 5'd29, 32'h2);
        wr_chk("lock_clear_ok", 5'd31, 32'h8000_0000, 1'b0);
        rd_chk("lock_cnt_cleared", 5'd30, 32'h0);
        rd_chk("lock_read_ok", 5'd2, 32'hA5A5_0F0F);
        check("lock_still", 64'(locked), 64'h1);

        // Asynchronous reset in LOCKED
        #2 rst = 1'b1;
        #1;
        check("arst_lock_locked", 64'(locked), 64'h0);
        check("arst_lock_reglk", 64'(reglk != 0), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("arst_lock_ctrl", 5'd31, 32'h0);
        rd_chk("arst_lock_sh0", 5'd0, 32'h0);

        // Asynchronous reset mid-COMMIT aborts the commit
        wr_chk("abort_sh", 5'd3, 32'hDEAD_BEEF, 1'b0);
        wr_chk("abort_commit", 5'd31, 32'h1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_commit_reglk", 64'(reglk != 0), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("arst_commit_after", 64'(reglk != 0), 64'h0);
        rd_chk("arst_commit_ctrl", 5'd31, 32'h0);
        rd_chk("arst_commit_sh3", 5'd3, 32'h0);

        // Random shadow traffic against a model, then commit and compare the vector
        for (int i = 0; i < NB_WORDS; i++) model[i] = '0;
        for (int k = 0; k < 20; k++) begin
            int          w;
            logic [31:0] d;
            w = $urandom_range(0, NB_WORDS - 1);
            d = $urandom;
            model[w] = d;
            wr_chk("rand_wr", 5'(w), d, 1'b0);
        end
        for (int i = 0; i < NB_WORDS; i++) rd_chk($sformatf("rand_rd%0d", i), 5'(i), model[i]);
        wr_chk("rand_commit", 5'd31, 32'h1, 1'b0);
        idle();
        for (int i = 0; i < NB_WORDS; i++) flat[i*32 +: 32] = model[i];
        check("rand_reglk_lo", reglk[63:0], flat[63:0]);
        check("rand_reglk_mid", reglk[127:64], flat[127:64]);
        check("rand_reglk_hi", reglk[191:128], flat[191:128]);

        // Saturation under lock_wr_i, then lock_rd_i masking
        wr_chk("sat_setup", 5'd1, 32'h0BAD_F00D, 1'b0);
        wr_chk("sat_commit", 5'd31, 32'h1, 1'b0);
        idle();
        wr_chk("sat_sel", 5'd29, 32'h1, 1'b0);
        lock_wr = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wr_chk("sat_err", 5'd1, $urandom, 1'b1);
            check("sat_viol", 64'(viol), 64'h1);
        end
        rd_chk("sat_cnt", 5'd30, 32'h0000_00FF);
        wr_chk("sat_clear_blocked", 5'd31, 32'h8000_0000, 1'b1);
        rd_chk("sat_cnt_kept", 5'd30, 32'h0000_00FF);
        lock_wr = 1'b0;
        idle();
        check("sat_viol_drop", 64'(viol), 64'h0);
        rd_chk("sat_sh1", 5'd1, 32'h0BAD_F00D);
        lock_rd = 1'b1;
        rd_chk("lrd_sh1", 5'd1, 32'h0);
        rd_chk("lrd_act", 5'd28, 32'h0);
        rd_chk("lrd_viol", 5'd30, 32'h0000_00FF);
        lock_rd = 1'b0;
        rd_chk("act_sel1", 5'd28, 32'h0BAD_F00D);
        wr_chk("sel_oob", 5'd29, 32'h6, 1'b0);
        rd_chk("act_oob", 5'd28, 32'h0);
        rd_chk("cnt_after_reads", 5'd30, 32'h0000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
